// File: rtl/mdr_pkg.sv
// Shared types and helpers for the memory-data/memory-address register block:
// FSM state, access-size codes, timeout counter sizing and alignment check.
package mdr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } mdr_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Wide enough to hold 0..cycles.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

  // Size code 2'b11 is handled as a word access.
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lane[0];
      default: return (lane != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mdr_lane_align.sv
// Sub-word lane steering for a 32-bit memory port: store replication and byte
// enables, load extraction with zero/sign extension. Only built with MDR_SUBWORD_EN.
`ifdef MDR_SUBWORD_EN
module mdr_lane_align
  import mdr_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_sext,
  input  logic [31:0] i_store,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_load
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_lane, 3'b000} +: 8];
  assign w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_wdata = i_store;
    o_be    = 4'hF;
    o_load  = i_rdata;
    case (i_size)
      SZ_BYTE: begin
        o_wdata = {4{i_store[7:0]}};
        o_be    = 4'b0001 << i_lane;
        o_load  = {{24{i_sext & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_wdata = {2{i_store[15:0]}};
        o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
        o_load  = {{16{i_sext & w_half[15]}}, w_half};
      end
      default: ;
    endcase
  end

endmodule
`endif

// File: rtl/mdr_mem_if.sv
// MAR/MDR pair with a req/ack memory handshake, wait-state timeout and sticky
// error. Optional sub-word access (byte/half, WIDTH = 32) under MDR_SUBWORD_EN.
module mdr_mem_if
  import mdr_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mar_en,
  input  logic                  mdr_en,
  input  logic [WIDTH-1:0]      bus_in,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  output logic [ADDR_WIDTH-1:0] mar_out,
  output logic [WIDTH-1:0]      mdr_out,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic [WIDTH/8-1:0]    mem_be,
  input  logic [WIDTH-1:0]      mem_rdata,
  input  logic                  mem_ack
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES);

  mdr_state_e            r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_mar;
  logic [WIDTH-1:0]      r_mdr;
  logic [CW-1:0]         r_cnt;
  logic                  r_done;
  logic                  r_error;
  logic                  w_start;
  logic                  w_misal;
  logic                  w_tmo;
  logic [WIDTH-1:0]      w_load;

  assign w_start = (r_state == IDLE) && (mem_read || mem_write);
  assign w_tmo   = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

`ifdef MDR_SUBWORD_EN
  // Size and extension are latched at start so the lanes stay stable while waiting.
  logic [1:0]            r_size;
  logic                  r_sext;
  logic [ADDR_WIDTH-1:0] w_mar_nxt;

  assign w_mar_nxt = mar_en ? ADDR_WIDTH'(bus_in) : r_mar;
  assign w_misal   = misaligned(size, w_mar_nxt[1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_size <= SZ_WORD;
      r_sext <= 1'b0;
    end else if (w_start) begin
      r_size <= size;
      r_sext <= sign_ext;
    end
  end

  mdr_lane_align u_lane (
    .i_size  (r_size),
    .i_lane  (r_mar[1:0]),
    .i_sext  (r_sext),
    .i_store (r_mdr),
    .i_rdata (mem_rdata),
    .o_wdata (mem_wdata),
    .o_be    (mem_be),
    .o_load  (w_load)
  );
`else
  logic w_unused;

  assign w_unused  = ^{size, sign_ext};
  assign w_misal   = 1'b0;
  assign mem_wdata = r_mdr;
  assign mem_be    = '1;
  assign w_load    = mem_rdata;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mar   <= '0;
      r_mdr   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (mar_en) r_mar <= ADDR_WIDTH'(bus_in);
        if (mdr_en) r_mdr <= bus_in;
        // A misaligned start completes at once with the error raised.
        if (w_start) begin
          r_cnt   <= '0;
          r_error <= w_misal;
          r_done  <= w_misal;
        end
      end else if (mem_ack) begin
        if (r_state == RD_WAIT) r_mdr <= w_load;
        r_done <= 1'b1;
      end else if (w_tmo) begin
        r_error <= 1'b1;
        r_done  <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start && !w_misal) w_state_nxt = mem_read ? RD_WAIT : WR_WAIT;
      end
      RD_WAIT: begin
        mem_req = 1'b1;
        busy    = 1'b1;
        if (mem_ack || w_tmo) w_state_nxt = IDLE;
      end
      WR_WAIT: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        busy    = 1'b1;
        if (mem_ack || w_tmo) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign mar_out  = r_mar;
  assign mdr_out  = r_mdr;
  assign mem_addr = r_mar;
  assign done     = r_done;
  assign error    = r_error;

endmodule

// File: tb/tb_mdr_mem_if.sv
// Self-checking bench for mdr_mem_if: table of transfers with a scoreboard queue,
// plus hand sequences for timeout, collisions, idle ack and reset mid-transfer.
module tb_mdr_mem_if;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic        mar_en, mdr_en, mem_read, mem_write, sign_ext, mem_ack;
  logic [31:0] bus_in, mem_rdata;
  logic [1:0]  size;
  logic [31:0] mar_out, mdr_out, mem_addr, mem_wdata;
  logic        busy, done, error, mem_req, mem_we;
  logic [3:0]  mem_be;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          waits;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] exp;
    logic [3:0]  be;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  logic [31:0] m_mdr;
  int          n_cmp = 0;
  int          n_bad = 0;

  mdr_mem_if #(.WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .mar_en    (mar_en),
    .mdr_en    (mdr_en),
    .bus_in    (bus_in),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .size      (size),
    .sign_ext  (sign_ext),
    .mar_out   (mar_out),
    .mdr_out   (mdr_out),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic load_mar(input logic [31:0] a);
    @(negedge clk);
    bus_in = a;
    mar_en = 1'b1;
    @(negedge clk);
    mar_en = 1'b0;
  endtask

  // One full transfer: MAR load, start (write loads MDR on the same edge), wait loop.
  task automatic xfer(input vec_t v);
    logic [31:0] wcap;
    int          reqs;
    int          cyc;
    wcap = '0;
    reqs = 0;
    cyc  = 0;
    load_mar(v.addr);
    size     = v.sz;
    sign_ext = v.sx;
    if (v.wr) begin
      bus_in    = v.data;
      mdr_en    = 1'b1;
      mem_write = 1'b1;
    end else begin
      mem_read = 1'b1;
    end
    exp_q.push_back(v.exp);
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mdr_en    = 1'b0;
    bus_in    = $urandom;
    size      = 2'($urandom_range(0, 3));
    sign_ext  = 1'($urandom_range(0, 1));
    while (!done && cyc < 40) begin
      if (mem_req) begin
        chk("req_addr", mem_addr, v.addr);
        chk("req_we", {31'b0, mem_we}, {31'b0, v.wr});
        chk("req_be", {28'b0, mem_be}, {28'b0, v.be});
        chk("req_busy", {31'b0, busy}, 32'd1);
        if (v.wr) wcap = mem_wdata;
        mem_ack   = (reqs == v.waits);
        mem_rdata = v.wr ? $urandom : v.data;
        reqs++;
      end
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      cyc++;
    end
    chk("done_seen", {31'b0, done}, 32'd1);
    chk("req_cycles", reqs, v.waits + 1);
    chk("busy_at_done", {31'b0, busy}, 32'd0);
    chk("req_at_done", {31'b0, mem_req}, 32'd0);
    chk("error_at_done", {31'b0, error}, 32'd0);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_empty: got 0 entries want 1");
    end else begin
      chk(v.wr ? "sb_wdata" : "sb_mdr", v.wr ? wcap : mdr_out, exp_q.pop_front());
    end
    if (v.wr) chk("mdr_after_wr", mdr_out, v.data);
    m_mdr = v.wr ? v.data : v.exp;
    @(negedge clk);
    chk("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  initial begin
    int reqs;
    int cyc;
    reset = 1'b1; mar_en = 0; mdr_en = 0; mem_read = 0; mem_write = 0;
    size = SZ_WORD; sign_ext = 0; mem_ack = 0; bus_in = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_mar", mar_out, 32'h0);
    chk("rst_mdr", mdr_out, 32'h0);
    chk("rst_flags", {27'b0, busy, done, error, mem_req, mem_we}, 32'h0);
    chk("rst_be", {28'b0, mem_be}, 32'hF);

    // wr, addr, data, waits, size, sext, expected (wdata or mdr), be
    vecs.push_back('{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 3, SZ_WORD, 1'b0, 32'hDEAD_BEEF, 4'hF});
    vecs.push_back('{1'b0, 32'h0000_0200, 32'h1234_5678, 0, SZ_WORD, 1'b0, 32'h1234_5678, 4'hF});
    vecs.push_back('{1'b0, 32'h0000_0204, 32'hA5A5_0F0F, 2, SZ_WORD, 1'b0, 32'hA5A5_0F0F, 4'hF});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'h0000_0001, 0, SZ_WORD, 1'b0, 32'h0000_0001, 4'hF});
    vecs.push_back('{1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1, SZ_WORD, 1'b0, 32'hFFFF_FFFF, 4'hF});
`ifdef MDR_SUBWORD_EN
    vecs.push_back('{1'b0, 32'h0000_0003, 32'h80FF_FFFF, 0, SZ_BYTE, 1'b1, 32'hFFFF_FF80, 4'b1000});
    vecs.push_back('{1'b1, 32'h0000_0002, 32'h0000_00AB, 1, SZ_BYTE, 1'b0, 32'hABAB_ABAB, 4'b0100});
    vecs.push_back('{1'b0, 32'h0000_0002, 32'h8001_1234, 2, SZ_HALF, 1'b0, 32'h0000_8001, 4'b1100});
    vecs.push_back('{1'b0, 32'h0000_0001, 32'h0000_9A00, 0, SZ_BYTE, 1'b0, 32'h0000_009A, 4'b0010});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'h0000_BEEF, 0, SZ_HALF, 1'b0, 32'hBEEF_BEEF, 4'b0011});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h1234_F00D, 1, SZ_HALF, 1'b1, 32'hFFFF_F00D, 4'b0011});
`endif
    for (int i = 0; i < 4; i++) begin
      vec_t r;
      r.wr    = 1'b0;
      r.addr  = $urandom & 32'hFFFF_FFFC;
      r.data  = $urandom;
      r.waits = $urandom_range(0, 3);
      r.sz    = SZ_WORD;
      r.sx    = 1'($urandom_range(0, 1));
      r.exp   = r.data;
      r.be    = 4'hF;
      vecs.push_back(r);
    end
    for (int i = 0; i < vecs.size(); i++) xfer(vecs[i]);

    // Timeout: never acknowledge; four request cycles, then error and done.
    size = SZ_WORD;
    @(negedge clk);
    mem_read = 1'b1;
    @(negedge clk);
    mem_read = 1'b0;
    reqs = 0;
    cyc  = 0;
    while (!done && cyc < 40) begin
      if (mem_req) reqs++;
      @(negedge clk);
      cyc++;
    end
    chk("tmo_req_cycles", reqs, 4);
    chk("tmo_done", {31'b0, done}, 32'd1);
    chk("tmo_error", {31'b0, error}, 32'd1);
    chk("tmo_req_dropped", {31'b0, mem_req}, 32'd0);
    chk("tmo_mdr_kept", mdr_out, m_mdr);
    @(negedge clk);
    chk("tmo_done_pulse", {31'b0, done}, 32'd0);
    chk("tmo_error_sticky", {31'b0, error}, 32'd1);

    // Ack while idle is ignored.
    mem_ack   = 1'b1;
    mem_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("idle_ack_mdr", mdr_out, m_mdr);
    chk("idle_ack_done", {31'b0, done}, 32'd0);
    chk("idle_ack_req", {31'b0, mem_req}, 32'd0);

    // Read and write together: read wins; bus loads during the wait are ignored.
    load_mar(32'h0000_0300);
    mem_read  = 1'b1;
    mem_write = 1'b1;
    @(negedge clk);
    chk("col_error_cleared", {31'b0, error}, 32'd0);
    chk("col_req", {31'b0, mem_req}, 32'd1);
    chk("col_we", {31'b0, mem_we}, 32'd0);
    mem_write = 1'b0;
    mdr_en    = 1'b1;
    mar_en    = 1'b1;
    bus_in    = 32'hCAFE_F00D;
    @(negedge clk);
    chk("col_addr_stable", mem_addr, 32'h0000_0300);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    mem_ack  = 1'b0;
    mem_read = 1'b0;
    mdr_en   = 1'b0;
    mar_en   = 1'b0;
    chk("col_done", {31'b0, done}, 32'd1);
    chk("col_mdr", mdr_out, 32'h0BAD_F00D);
    chk("col_mar", mar_out, 32'h0000_0300);
    m_mdr = 32'h0BAD_F00D;
    @(negedge clk);

`ifdef MDR_SUBWORD_EN
    // Misaligned half: no request, immediate error and done.
    load_mar(32'h0000_0001);
    size     = SZ_HALF;
    mem_read = 1'b1;
    @(negedge clk);
    mem_read = 1'b0;
    chk("mis_req", {31'b0, mem_req}, 32'd0);
    chk("mis_done", {31'b0, done}, 32'd1);
    chk("mis_error", {31'b0, error}, 32'd1);
    chk("mis_mdr", mdr_out, m_mdr);
    @(negedge clk);
    chk("mis_done_pulse", {31'b0, done}, 32'd0);
    size = SZ_WORD;
`endif

    // Reset in the middle of a read abandons it.
    load_mar(32'h0000_0400);
    mem_read = 1'b1;
    @(negedge clk);
    mem_read = 1'b0;
    @(negedge clk);
    chk("mid_req_before_rst", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_flags", {27'b0, busy, done, error, mem_req, mem_we}, 32'h0);
    chk("mid_rst_mdr", mdr_out, 32'h0);
    chk("mid_rst_mar", mar_out, 32'h0);
    chk("mid_rst_be", {28'b0, mem_be}, 32'hF);
    @(negedge clk);
    chk("mid_rst_no_done", {30'b0, done, mem_req}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
